led_pwm_sequencer: RTL and testbench



---
 rtl/led_pwm_sequencer_if.sv | 18 +
 rtl/led_pwm_sequencer.sv | 165 ++++++++++++++++
 tb/tb_led_pwm_sequencer.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/led_pwm_sequencer_if.sv
// Control/status bundle for the LED sequencer: run enable and mode select in, LED pin drive out.
interface led_pwm_sequencer_if;
    logic       en;
    logic [1:0] mode;
    logic [1:0] led;

    modport master (
        output en,
        output mode,
        input  led
    );

    modport slave (
        input  en,
        input  mode,
        output led
    );
endinterface

// File: rtl/led_pwm_sequencer.sv
// Mode-controlled LED sequencer: off, solid, square-wave blink, or PWM breathing,
// paced by a prescaled step tick and a free-running PWM counter.
module led_pwm_sequencer #(
    parameter int PRESCALE    = 1000000,
    parameter int PWM_BITS    = 8,
    parameter int STEP        = 1,
    parameter int HOLD_TICKS  = 64,
    parameter int BLINK_TICKS = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    led_pwm_sequencer_if.slave    ctrl
);

    localparam int PRE_W   = $clog2(PRESCALE);
    localparam int HOLD_W  = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int BLINK_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [BLINK_W-1:0]  BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX   = '1;
    localparam logic [PWM_BITS-1:0] STEP_V     = PWM_BITS'(STEP);

    typedef enum logic [1:0] {
        RAMP_UP = 2'd0,
        HOLD_HI = 2'd1,
        RAMP_DN = 2'd2,
        HOLD_LO = 2'd3
    } state_e;

    logic [PRE_W-1:0]    prescale_q,  prescale_d;
    logic [PWM_BITS-1:0] pwm_q,       pwm_d;
    logic [PWM_BITS-1:0] duty_q,      duty_d;
    state_e              state_q,     state_d;
    logic [HOLD_W-1:0]   hold_q,      hold_d;
    logic [BLINK_W-1:0]  blink_cnt_q, blink_cnt_d;
    logic                blink_q,     blink_d;
    logic [1:0]          led_q,       led_d;

    logic                tick;
    logic [PWM_BITS:0]   up_sum;
    logic [PWM_BITS-1:0] duty_up;
    logic [PWM_BITS-1:0] duty_dn;
    logic [PWM_BITS-1:0] duty_inv;
    logic                pwm_a;
    logic                pwm_b;

    // Prescaler and PWM counter both stall while disabled so the step phase survives a freeze.
    always_comb begin
        tick       = ctrl.en && (prescale_q == PRE_LAST);
        prescale_d = prescale_q;
        pwm_d      = pwm_q;
        if (ctrl.en) begin
            prescale_d = tick ? '0 : prescale_q + 1'b1;
            pwm_d      = pwm_q + 1'b1;
        end
    end

    // Saturating duty arithmetic; the extra sum bit catches overflow past full scale.
    always_comb begin
        up_sum  = {1'b0, duty_q} + {1'b0, STEP_V};
        duty_up = (up_sum > {1'b0, DUTY_MAX}) ? DUTY_MAX : up_sum[PWM_BITS-1:0];
        duty_dn = (duty_q < STEP_V) ? '0 : duty_q - STEP_V;
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        hold_d  = hold_q;
        if (tick) begin
            unique case (state_q)
                RAMP_UP: begin
                    duty_d = duty_up;
                    if (duty_up == DUTY_MAX) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_DN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RAMP_DN: begin
                    duty_d = duty_dn;
                    if (duty_dn == '0) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RAMP_UP;
                    hold_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // LED b uses the complementary duty so the two LEDs breathe in opposition.
    always_comb begin
        duty_inv = DUTY_MAX - duty_q;
        pwm_a    = (pwm_q < duty_q);
        pwm_b    = (pwm_q < duty_inv);
        led_d    = 2'b00;
        if (ctrl.en) begin
            unique case (ctrl.mode)
                2'd0:    led_d = 2'b00;
                2'd1:    led_d = 2'b01;
                2'd2:    led_d = {~blink_q, blink_q};
                2'd3:    led_d = {pwm_b, pwm_a};
                default: led_d = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_q  <= '0;
            pwm_q       <= '0;
            duty_q      <= '0;
            state_q     <= RAMP_UP;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            led_q       <= 2'b00;
        end else begin
            prescale_q  <= prescale_d;
            pwm_q       <= pwm_d;
            duty_q      <= duty_d;
            state_q     <= state_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            led_q       <= led_d;
        end
    end

    assign ctrl.led = led_q;

endmodule

// File: tb/tb_led_pwm_sequencer.sv
// Self-checking bench for led_pwm_sequencer: a behavioural model feeds a scoreboard queue,
// a vector table sweeps modes, and hand-written sequences cover reset, freeze and breathing.
module tb_led_pwm_sequencer;

   localparam int PRESCALE    = 4;
   localparam int PWM_BITS    = 4;
   localparam int STEP        = 1;
   localparam int HOLD_TICKS  = 2;
   localparam int BLINK_TICKS = 3;
   localparam int MAXV        = (1 << PWM_BITS) - 1;

   logic clk;
   logic rst_n;

   led_pwm_sequencer_if bus ();
   led_pwm_sequencer_if bus2 ();

   led_pwm_sequencer #(
      .PRESCALE(PRESCALE), .PWM_BITS(PWM_BITS), .STEP(STEP),
      .HOLD_TICKS(HOLD_TICKS), .BLINK_TICKS(BLINK_TICKS)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .ctrl(bus)
   );

   // Slow-stepping second instance holds each duty for a full PWM period.
   led_pwm_sequencer #(
      .PRESCALE(16), .PWM_BITS(PWM_BITS), .STEP(STEP),
      .HOLD_TICKS(HOLD_TICKS), .BLINK_TICKS(BLINK_TICKS)
   ) dut2 (
      .clk(clk),
      .rst_n(rst_n),
      .ctrl(bus2)
   );

   assign bus2.en   = 1'b1;
   assign bus2.mode = 2'd3;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit         en;
      logic [1:0] mode;
      int         cycles;
      bit         checkConst;
      logic [1:0] constLed;
      bit         checkAlt;
   } vec_t;

   vec_t vecs[7];

   int checks = 0;
   int passes = 0;
   int expq[$];

   int mPre, mPwm, mDuty, mState, mHold, mBcnt, mBlink;

   // Watchdog so a stuck run still ends with a reported failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual == expected) passes++;
      else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
   endtask

   task automatic modelReset();
      mPre = 0; mPwm = 0; mDuty = 0; mState = 0; mHold = 0; mBcnt = 0; mBlink = 0;
   endtask

   // Reference model of one clock edge; the led value is derived from pre-edge state.
   task automatic modelEdge(input bit e, input int md);
      int  nled;
      bit  tick;
      nled = 0;
      if (e) begin
         case (md)
            1: nled = 1;
            2: nled = mBlink ? 1 : 2;
            3: nled = ((mPwm < MAXV - mDuty) ? 2 : 0) | ((mPwm < mDuty) ? 1 : 0);
            default: nled = 0;
         endcase
         tick = (mPre == PRESCALE - 1);
         mPre = tick ? 0 : mPre + 1;
         mPwm = (mPwm + 1) % (MAXV + 1);
         if (tick) begin
            case (mState)
               0: begin
                  mDuty = (mDuty + STEP > MAXV) ? MAXV : mDuty + STEP;
                  if (mDuty == MAXV) begin mState = 1; mHold = 0; end
               end
               1: if (mHold == HOLD_TICKS - 1) begin mState = 2; mHold = 0; end else mHold++;
               2: begin
                  mDuty = (mDuty - STEP < 0) ? 0 : mDuty - STEP;
                  if (mDuty == 0) begin mState = 3; mHold = 0; end
               end
               default: if (mHold == HOLD_TICKS - 1) begin mState = 0; mHold = 0; end else mHold++;
            endcase
            if (mBcnt == BLINK_TICKS - 1) begin mBcnt = 0; mBlink ^= 1; end
            else mBcnt++;
         end
      end
      expq.push_back(nled);
   endtask

   // Drive inputs, let one edge pass, then compare led against the scoreboard head.
   task automatic applyStimulus(input bit e, input logic [1:0] md);
      int exp;
      bus.en   = e;
      bus.mode = md;
      @(posedge clk);
      modelEdge(e, int'(md));
      #1;
      if (expq.size() == 0) begin
         checkOutput("scoreboard_empty", 1, 0);
      end else begin
         exp = expq.pop_front();
         checkOutput("led", int'(bus.led), exp);
      end
   endtask

   initial begin
      int  cntA;
      int  cntB;
      int  preSaved;
      int  n;
      bit  found;

      vecs[0] = '{1'b1, 2'd1, 100, 1'b1, 2'b01, 1'b0};
      vecs[1] = '{1'b1, 2'd2,  60, 1'b0, 2'b00, 1'b1};
      vecs[2] = '{1'b1, 2'd0,  20, 1'b1, 2'b00, 1'b0};
      vecs[3] = '{1'b0, 2'd3,  30, 1'b1, 2'b00, 1'b0};
      vecs[4] = '{1'b1, 2'd3,  40, 1'b0, 2'b00, 1'b0};
      vecs[5] = '{1'b0, 2'd2,  10, 1'b1, 2'b00, 1'b0};
      vecs[6] = '{1'b1, 2'd2,  30, 1'b0, 2'b00, 1'b1};

      // Reset held with the sequencer requested to run.
      rst_n    = 1'b0;
      bus.en   = 1'b1;
      bus.mode = 2'd3;
      modelReset();
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         checkOutput("reset_led", int'(bus.led), 0);
      end
      checkOutput("reset_duty", int'(dut.duty_q), 0);
      checkOutput("reset_state", int'(dut.state_q), 0);
      rst_n = 1'b1;

      // Breathing from reset, with ramp/hold landmarks and a PWM duty census on dut2.
      cntA = 0;
      cntB = 0;
      for (int i = 1; i <= 140; i++) begin
         applyStimulus(1'b1, 2'd3);
         if (i >= 81 && i <= 96) begin
            cntA += int'(bus2.led[0]);
            cntB += int'(bus2.led[1]);
         end
         case (i)
            3:   checkOutput("first_tick_pre", int'(dut.duty_q), 0);
            4:   checkOutput("first_tick", int'(dut.duty_q), 1);
            59:  checkOutput("ramp_up_59", int'(dut.duty_q), 14);
            60: begin
               checkOutput("ramp_top", int'(dut.duty_q), 15);
               checkOutput("enter_hold_hi", int'(dut.state_q), 1);
            end
            67:  checkOutput("hold_hi_67", int'(dut.state_q), 1);
            68:  checkOutput("leave_hold_hi", int'(dut.state_q), 2);
            72:  checkOutput("ramp_dn_first", int'(dut.duty_q), 14);
            127: checkOutput("ramp_dn_127", int'(dut.duty_q), 1);
            128: begin
               checkOutput("ramp_bottom", int'(dut.duty_q), 0);
               checkOutput("enter_hold_lo", int'(dut.state_q), 3);
            end
            136: checkOutput("leave_hold_lo", int'(dut.state_q), 0);
            140: checkOutput("ramp_up_again", int'(dut.duty_q), 1);
            default: ;
         endcase
      end
      checkOutput("pwm_a_high_count", cntA, 5);
      checkOutput("pwm_b_high_count", cntB, 10);

      // Vector table sweep over modes and enable.
      for (int v = 0; v < 7; v++) begin
         for (int c = 0; c < vecs[v].cycles; c++) begin
            applyStimulus(vecs[v].en, vecs[v].mode);
            if (c > 0 && vecs[v].checkConst)
               checkOutput("const_led", int'(bus.led), int'(vecs[v].constLed));
            if (vecs[v].checkAlt)
               checkOutput("blink_alternates", int'(bus.led == 2'b01 || bus.led == 2'b10), 1);
         end
      end

      // Freeze at duty 7 on the way up, then resume with the prescale phase intact.
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         applyStimulus(1'b1, 2'd3);
         if (mDuty == 7 && mState == 0) found = 1'b1;
      end
      checkOutput("reach_duty7", int'(found), 1);
      if (found) begin
         preSaved = mPre;
         for (int i = 0; i < 50; i++) begin
            applyStimulus(1'b0, 2'd3);
            checkOutput("freeze_led", int'(bus.led), 0);
         end
         checkOutput("freeze_duty", int'(dut.duty_q), 7);
         n = PRESCALE - preSaved;
         for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b1, 2'd3);
            if (k == n - 1) checkOutput("resume_hold7", int'(dut.duty_q), 7);
            if (k == n)     checkOutput("resume_step8", int'(dut.duty_q), 8);
         end
      end

      // Asynchronous reset pulse between edges while in HOLD_HI with the LED lit solid.
      found = 1'b0;
      for (int i = 0; i < 400 && !found; i++) begin
         applyStimulus(1'b1, 2'd1);
         if (mState == 1) found = 1'b1;
      end
      checkOutput("reach_hold_hi", int'(found), 1);
      applyStimulus(1'b1, 2'd1);
      applyStimulus(1'b1, 2'd1);
      checkOutput("pre_pulse_led", int'(bus.led), 1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_led", int'(bus.led), 0);
      checkOutput("async_duty", int'(dut.duty_q), 0);
      checkOutput("async_state", int'(dut.state_q), 0);
      modelReset();
      #1;
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, 2'd3);
         if (k == 3) checkOutput("post_reset_pre_tick", int'(dut.duty_q), 0);
         if (k == 4) checkOutput("post_reset_tick", int'(dut.duty_q), 1);
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
